// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between two ALU clients and the shared ALU arbiter.
// The master side is the pair of requesters, the slave side is the arbiter.
interface alu_share_arbiter_if #(
  parameter int unsigned CNT_W = 16
);
  logic              req0_valid;
  logic              req0_ready;
  logic [31:0]       req0_a;
  logic [31:0]       req0_b;
  logic [3:0]        req0_ctrl;

  logic              req1_valid;
  logic              req1_ready;
  logic [31:0]       req1_a;
  logic [31:0]       req1_b;
  logic [3:0]        req1_ctrl;

  logic              rsp0_valid;
  logic              rsp0_ready;
  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [31:0]       rsp_result;
  logic              rsp_zero;
  logic              rsp_err;

  logic              busy;
  logic [CNT_W-1:0]  op_count;

  modport master (
    output req0_valid, req0_a, req0_b, req0_ctrl,
    output req1_valid, req1_a, req1_b, req1_ctrl,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_result, rsp_zero, rsp_err,
    input  busy, op_count
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_ctrl,
    input  req1_valid, req1_a, req1_b, req1_ctrl,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_result, rsp_zero, rsp_err,
    output busy, op_count
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// One 32-bit ALU shared by two requesters: round-robin grant, one operation in flight,
// registered operands and result, response routed back to the issuing requester.
module alu_share_arbiter #(
  parameter int unsigned CNT_W = 16
) (
  input logic                clk,
  input logic                rst_n,
  alu_share_arbiter_if.slave bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StExec = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  localparam logic [3:0] CtrlAnd = 4'b0000;
  localparam logic [3:0] CtrlOr  = 4'b0001;
  localparam logic [3:0] CtrlAdd = 4'b0010;
  localparam logic [3:0] CtrlSub = 4'b0110;
  localparam logic [3:0] CtrlSlt = 4'b0111;
  localparam logic [3:0] CtrlNor = 4'b1100;

  logic [1:0]       state_q, state_d;
  logic             last_grant_q;
  logic             owner_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [3:0]       ctrl_q;
  logic [31:0]      result_q;
  logic             zero_q;
  logic             err_q;
  logic [CNT_W-1:0] op_count_q;

  logic             grant;
  logic             grant_valid;
  logic             req_hs;
  logic             rsp_hs;
  logic [31:0]      alu_result;
  logic             alu_err;
  logic             alu_zero;

  // Round-robin: on contention the requester that did not win last time goes next.
  always_comb begin
    grant_valid = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      grant = ~last_grant_q;
    end else begin
      grant = bus.req1_valid;
    end
  end

  // rst_n gate keeps both readies low while reset is held, even with valids up.
  assign req_hs         = rst_n && (state_q == StIdle) && grant_valid;
  assign bus.req0_ready = req_hs && !grant;
  assign bus.req1_ready = req_hs && grant;

  assign rsp_hs = (state_q == StResp) && (owner_q ? bus.rsp1_ready : bus.rsp0_ready);

  // Combinational ALU fed only from the latched operand registers.
  always_comb begin
    alu_result = 32'd0;
    alu_err    = 1'b0;
    case (ctrl_q)
      CtrlAnd: alu_result = a_q & b_q;
      CtrlOr:  alu_result = a_q | b_q;
      CtrlAdd: alu_result = a_q + b_q;
      CtrlSub: alu_result = a_q - b_q;
      CtrlSlt: alu_result = {31'd0, (a_q < b_q)};
      CtrlNor: alu_result = ~(a_q | b_q);
      default: begin
        alu_result = 32'd0;
        alu_err    = 1'b1;
      end
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (req_hs) begin
          state_d = StExec;
        end
      end
      StExec: begin
        state_d = StResp;
      end
      StResp: begin
        if (rsp_hs) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand capture at the request handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      a_q          <= 32'd0;
      b_q          <= 32'd0;
      ctrl_q       <= 4'd0;
    end else if (req_hs) begin
      last_grant_q <= grant;
      owner_q      <= grant;
      a_q          <= grant ? bus.req1_a : bus.req0_a;
      b_q          <= grant ? bus.req1_b : bus.req0_b;
      ctrl_q       <= grant ? bus.req1_ctrl : bus.req0_ctrl;
    end
  end

  // Result registers load only in EXEC, so they hold through RESP until the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= 32'd0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else if (state_q == StExec) begin
      result_q <= alu_result;
      zero_q   <= alu_zero;
      err_q    <= alu_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_q <= '0;
    end else if (rsp_hs) begin
      op_count_q <= op_count_q + CNT_W'(1);
    end
  end

  assign bus.rsp0_valid = (state_q == StResp) && !owner_q;
  assign bus.rsp1_valid = (state_q == StResp) && owner_q;
  assign bus.rsp_result = result_q;
  assign bus.rsp_zero   = zero_q;
  assign bus.rsp_err    = err_q;
  assign bus.busy       = (state_q != StIdle);
  assign bus.op_count   = op_count_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed operations, a transaction-level model checked
// on every falling edge, and literal expectations for the ALU reference.
module tb_alu_share_arbiter;

  localparam int unsigned CW = 4;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  c;
  } op_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  alu_share_arbiter_if #(.CNT_W(CW)) bus ();

  alu_share_arbiter #(.CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  op_t  q0[$];
  op_t  q1[$];
  int   grant_log[$];
  logic hs0 = 1'b0;
  logic hs1 = 1'b0;

  // Model state: one operation in flight, its age in cycles since acceptance.
  logic        pend = 1'b0;
  int          age = 0;
  logic        owner_m = 1'b0;
  logic        last_m = 1'b1;
  logic [33:0] exp_m = '0;
  int          cnt_m = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference ALU: {err, zero, result}.
  function automatic logic [33:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] c);
    logic [31:0] r;
    logic        e;
    e = 1'b0;
    case (c)
      4'd0:    r = a & b;
      4'd1:    r = a | b;
      4'd2:    r = a + b;
      4'd6:    r = a - b;
      4'd7:    r = (a < b) ? 32'd1 : 32'd0;
      4'd12:   r = ~(a | b);
      default: begin r = 32'd0; e = 1'b1; end
    endcase
    return {e, (r == 32'd0), r};
  endfunction

  // Per-cycle compare against the model.
  initial begin
    forever begin
      logic g, er0, er1, own_rdy;
      @(negedge clk);
      if (!rst_n) begin
        check("reset_ctl", {57'd0, bus.req0_ready, bus.req1_ready, bus.rsp0_valid,
                            bus.rsp1_valid, bus.busy, bus.rsp_err, bus.rsp_zero}, 64'd0);
        check("reset_result", {32'd0, bus.rsp_result}, 64'd0);
        check("reset_count", {60'd0, bus.op_count}, 64'd0);
        pend = 1'b0; age = 0; last_m = 1'b1; cnt_m = 0; hs0 = 1'b0; hs1 = 1'b0;
      end else begin
        g   = (bus.req0_valid && bus.req1_valid) ? !last_m : bus.req1_valid;
        er0 = !pend && bus.req0_valid && !g;
        er1 = !pend && bus.req1_valid && g;
        check("req0_ready", {63'd0, bus.req0_ready}, {63'd0, er0});
        check("req1_ready", {63'd0, bus.req1_ready}, {63'd0, er1});
        check("busy", {63'd0, bus.busy}, {63'd0, pend});
        check("op_count", {60'd0, bus.op_count}, 64'(cnt_m % (1 << CW)));
        if (pend && age >= 2) begin
          check("rsp0_valid", {63'd0, bus.rsp0_valid}, {63'd0, !owner_m});
          check("rsp1_valid", {63'd0, bus.rsp1_valid}, {63'd0, owner_m});
          check("rsp_data", {30'd0, bus.rsp_err, bus.rsp_zero, bus.rsp_result},
                {30'd0, exp_m});
        end else begin
          check("rsp_idle", {62'd0, bus.rsp0_valid, bus.rsp1_valid}, 64'd0);
        end
        hs0 = er0;
        hs1 = er1;
        own_rdy = owner_m ? bus.rsp1_ready : bus.rsp0_ready;
        if (pend) begin
          if (age >= 2 && own_rdy) begin
            pend = 1'b0;
            cnt_m++;
          end else begin
            age++;
          end
        end else if (er0 || er1) begin
          pend    = 1'b1;
          age     = 1;
          owner_m = er1;
          last_m  = er1;
          exp_m   = er1 ? alu_ref(bus.req1_a, bus.req1_b, bus.req1_ctrl)
                        : alu_ref(bus.req0_a, bus.req0_b, bus.req0_ctrl);
          grant_log.push_back(er1 ? 1 : 0);
        end
      end
    end
  end

  // A requester must keep valid up until its handshake.
  initial begin
    logic pv0, pv1;
    pv0 = 1'b0; pv1 = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        assert (!(pv0 && !bus.req0_valid)) else $error("req0_valid withdrawn without handshake");
        assert (!(pv1 && !bus.req1_valid)) else $error("req1_valid withdrawn without handshake");
        pv0 = bus.req0_valid && !bus.req0_ready;
        pv1 = bus.req1_valid && !bus.req1_ready;
      end else begin
        pv0 = 1'b0; pv1 = 1'b0;
      end
    end
  end

  // Requester drivers: present queued ops, hold each until accepted.
  initial begin
    forever begin
      op_t op;
      @(posedge clk);
      #2;
      if (!rst_n) begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end else begin
        if (bus.req0_valid && hs0) bus.req0_valid = 1'b0;
        if (!bus.req0_valid && q0.size() > 0) begin
          op = q0.pop_front();
          bus.req0_a = op.a; bus.req0_b = op.b; bus.req0_ctrl = op.c;
          bus.req0_valid = 1'b1;
        end
        if (bus.req1_valid && hs1) bus.req1_valid = 1'b0;
        if (!bus.req1_valid && q1.size() > 0) begin
          op = q1.pop_front();
          bus.req1_a = op.a; bus.req1_b = op.b; bus.req1_ctrl = op.c;
          bus.req1_valid = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || bus.req0_valid || bus.req1_valid || pend)
           && n < 200) begin
      tick();
      n++;
    end
    check(name, {63'd0, (n >= 200)}, 64'd0);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    q0.delete();
    q1.delete();
    repeat (2) tick();
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [CW-1:0] cnt_before;
    int            n;
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_ctrl = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_ctrl = '0;
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;

    // Pin the reference model with hand-computed values.
    check("ref_add", {30'd0, alu_ref(32'd5, 32'd7, 4'b0010)}, 64'h0_0000000C);
    check("ref_slt_unsigned", {30'd0, alu_ref(32'hFFFFFFFF, 32'd1, 4'b0111)}, 64'h1_00000000);
    check("ref_bad_code", {30'd0, alu_ref(32'd3, 32'd4, 4'b1111)}, 64'h3_00000000);
    check("ref_nor", {30'd0, alu_ref(32'd0, 32'd0, 4'b1100)}, 64'h0_FFFFFFFF);

    repeat (3) tick();
    #2;
    rst_n = 1'b1;
    tick();
    check("post_reset", {59'd0, bus.busy, bus.op_count}, 64'd0);

    // ADD from requester 0.
    q0.push_back('{32'd5, 32'd7, 4'b0010});
    drain("add_drain");
    check("add_result", {32'd0, bus.rsp_result}, 64'd12);
    check("add_count", {60'd0, bus.op_count}, 64'd1);

    // SUB then unsigned SLT from requester 1.
    q1.push_back('{32'd9, 32'd9, 4'b0110});
    q1.push_back('{32'hFFFFFFFF, 32'd1, 4'b0111});
    drain("sub_slt_drain");
    check("slt_result", {31'd0, bus.rsp_zero, bus.rsp_result}, 64'h1_00000000);

    // Contention from reset: strict alternation starting with requester 0.
    do_reset();
    grant_log.delete();
    q0.push_back('{32'd1, 32'd2, 4'b0010});
    q0.push_back('{32'hF0, 32'h0F, 4'b0001});
    q1.push_back('{32'd10, 32'd3, 4'b0110});
    q1.push_back('{32'hFF, 32'h0F, 4'b0000});
    drain("rr_drain");
    check("rr_len", 64'(grant_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
      check("rr_order", 64'(grant_log[i]), 64'(i % 2));
    end

    // Response backpressure on requester 0 while requester 1 waits.
    bus.rsp0_ready = 1'b0;
    q0.push_back('{32'd100, 32'd1, 4'b0110});
    q1.push_back('{32'd2, 32'd2, 4'b0010});
    n = 0;
    while (!bus.rsp0_valid && n < 20) begin tick(); n++; end
    check("stall_rsp_seen", {63'd0, bus.rsp0_valid}, 64'd1);
    cnt_before = bus.op_count;
    repeat (5) begin
      tick();
      check("stall_hold", {60'd0, bus.rsp0_valid, bus.req0_ready, bus.req1_ready, bus.busy},
            64'b1001);
      check("stall_result", {32'd0, bus.rsp_result}, 64'd99);
    end
    bus.rsp0_ready = 1'b1;
    tick();
    check("stall_release_count", {60'd0, bus.op_count}, {60'd0, cnt_before + CW'(1)});
    drain("stall_drain");

    // Unsupported code, then NOR.
    q0.push_back('{32'd3, 32'd4, 4'b1111});
    drain("bad_drain");
    check("bad_flags", {30'd0, bus.rsp_err, bus.rsp_zero, bus.rsp_result}, 64'h3_00000000);
    q0.push_back('{32'd0, 32'd0, 4'b1100});
    drain("nor_drain");
    check("nor_flags", {31'd0, bus.rsp_err, bus.rsp_result}, 64'h0_FFFFFFFF);

    // Reset while the operation sits in EXEC: dropped, no response, req0 wins next.
    q0.push_back('{32'd7, 32'd8, 4'b0010});
    n = 0;
    while (!pend && n < 20) begin tick(); n++; end
    check("exec_busy", {63'd0, bus.busy}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_immediate", {23'd0, bus.req0_ready, bus.req1_ready, bus.rsp0_valid,
                            bus.rsp1_valid, bus.busy, bus.rsp_err, bus.rsp_zero,
                            bus.op_count, bus.rsp_result}, 64'd0);
    tick();
    #2;
    rst_n = 1'b1;
    repeat (5) tick();
    check("no_stale_rsp", {62'd0, bus.rsp0_valid, bus.rsp1_valid}, 64'd0);
    grant_log.delete();
    q0.push_back('{32'd1, 32'd1, 4'b0010});
    q1.push_back('{32'd2, 32'd2, 4'b0010});
    drain("post_rst_drain");
    check("post_rst_first", (grant_log.size() > 0) ? 64'(grant_log[0]) : 64'd9, 64'd0);

    // Counter wrap at 2^CW - 1.
    do_reset();
    for (int i = 0; i < (1 << CW) - 1; i++) q0.push_back('{32'(i), 32'd1, 4'b0010});
    drain("wrap_fill");
    check("wrap_max", {60'd0, bus.op_count}, 64'((1 << CW) - 1));
    q1.push_back('{32'd4, 32'd4, 4'b0110});
    drain("wrap_last");
    check("wrap_zero", {60'd0, bus.op_count}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one 32-bit ALU instance between two requesters, e.g. the main datapath port and a second client such as a branch or address unit.
- Round-robin arbitration, valid/ready handshake on both the request and response sides, one operation outstanding at a time.
- Operands and result are registered. Each response is routed back to the requester that issued it.
- Also flags unsupported ALUControl codes and counts completed operations.

Parameters:
- CNT_W, 16: width of the completed-operation counter.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a, req0_b  in  32 each  requester 0 operands
- req0_ctrl  in  4  requester 0 ALUControl code
- req1_valid, req1_ready, req1_a, req1_b, req1_ctrl  same as requester 0, for requester 1
- rsp0_valid  out  1  response for requester 0 pending
- rsp0_ready  in  1  requester 0 takes the response
- rsp1_valid  out  1  response for requester 1 pending
- rsp1_ready  in  1  requester 1 takes the response
- rsp_result  out  32  registered ALU result, shared by both response channels
- rsp_zero  out  1  registered zero flag
- rsp_err  out  1  ALUControl code was not one of 0000, 0001, 0010, 0110, 0111, 1100
- busy  out  1  state is not IDLE
- op_count  out  CNT_W  number of completed response handshakes; wraps modulo 2^CNT_W

Behaviour:
- Reset (async assert, sync release) clears:
  - state to IDLE
  - reqX_ready, rspX_valid, busy to 0
  - rsp_result, rsp_zero, rsp_err, op_count to 0
  - last_grant to 1, so requester 0 wins first
- FSM state IDLE:
  - Grant is combinational from the valids and last_grant.
  - Only one requester valid: that one is granted.
  - Both valid: the requester not equal to last_grant is granted.
  - reqX_ready = (state==IDLE) && grant==X; never high in any other state; req0_ready and req1_ready are never high together.
  - On handshake (valid && ready), latch operands, ctrl and owner; last_grant <= owner; go to EXEC.
- FSM state EXEC, exactly 1 cycle:
  - ALU instance is driven from the latched registers.
  - Register result and zero; register rsp_err from the code check.
  - Go to RESP.
- FSM state RESP:
  - rsp{owner}_valid = 1; the other rspX_valid = 0.
  - rsp_result, rsp_zero and rsp_err hold stable until the handshake.
  - On rsp{owner}_valid && rsp{owner}_ready: op_count += 1, go to IDLE. The ready of the non-owner is ignored.
- Latency and throughput:
  - Request accepted at cycle N gives rsp_valid high at N+2.
  - No new request is accepted in the handshake cycle of a response.
  - Peak throughput is one operation per 3 cycles.
- Arithmetic follows the ALU exactly:
  - add and sub wrap modulo 2^32.
  - SLT is an unsigned compare.
  - An unsupported code gives result 0, zero 1, err 1.
- Protocol:
  - A requester holds valid and its operands stable until ready. Dropping valid without a handshake is a protocol violation; the bench asserts on it.
  - A requester that is not granted sees ready low and keeps waiting; round-robin bounds its wait to one operation.
- Reset mid-operation: any latched or pending operation is discarded, with no response issued; all outputs return to their reset values.
- op_count at its maximum wraps to 0 on the next completion.

Test Plan:
- After reset, req0 only, ADD a=5 b=7 ctrl=0010 -> req0_ready high in the accept cycle; rsp0_valid at +2 with result=12, zero=0, err=0; rsp1_valid stays 0; op_count=1 after the handshake.
- req1 SUB a=9 b=9 ctrl=0110 -> rsp1_valid, result=0, zero=1; then SLT a=0xFFFFFFFF b=1 -> result=0 (unsigned compare).
- Both valid continuously from reset, 4 operations -> grant order 0,1,0,1; each response routed to the matching rspX only.
- rsp0_ready held low for 5 cycles in RESP -> rsp0_valid, result and err stable; both req_ready stay 0; busy=1; on release, one handshake and op_count increments once.
- Unsupported code 1111 with a=3 b=4 -> result=0, zero=1, err=1. NOR a=0 b=0 ctrl=1100 -> result=0xFFFFFFFF, err=0.
- rst_n asserted during EXEC -> all outputs 0 immediately; after release no response for the dropped operation; next request from req0 wins (last_grant=1). Force op_count to 2^CNT_W-1 and complete one operation -> op_count wraps to 0.
